// File: rtl/sram_l2_burst_if.sv
// Request/response bus of the L2 burst SRAM. The master drives requests and
// the slave (the SRAM block) drives ready and the response beats.
interface sram_l2_burst_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 14,
  parameter int TAG_W  = 5
);
  logic              mem_req_val;
  logic              mem_req_rdy;
  logic [1:0]        mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [TAG_W-1:0]  mem_req_tag;
  logic              mem_resp_val;
  logic              mem_resp_nack;
  logic [DATA_W-1:0] mem_resp_data;
  logic [TAG_W-1:0]  mem_resp_tag;

  modport master (
    output mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_rdy, mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
  );

  modport slave (
    input  mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_rdy, mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
  );
endinterface

// File: rtl/sram_l2_burst.sv
// Single-port L2 SRAM with single/burst loads and stores. Accepted requests are
// registered, issued to the SRAM the next cycle, and loads respond 1+RD_LAT later.
module sram_l2_burst #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384,
  parameter int TAG_W  = 5,
  parameter int BURST  = 4,
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  sram_l2_burst_if.slave  bus
);
  localparam int CW     = $clog2(BURST);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } sram_req_t;

  typedef struct packed {
    logic             nack;
    logic [TAG_W-1:0] tag;
  } meta_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [TAG_W-1:0]  btag, btag_n;
  sram_req_t         rq, rq_n;
  logic              rd_n;
  logic              rdy_en;
  logic              acc;
  logic              last;
  logic [RD_LAT:0]   vld_pipe;

  // rdy_en keeps ready low during reset and rises on the first edge after it
  assign bus.mem_req_rdy = rdy_en & (state != RD_BURST);
  assign acc  = bus.mem_req_val & bus.mem_req_rdy;
  assign last = (cnt == CW'(BURST - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    base_n  = base;
    btag_n  = btag;
    rq_n    = '0;
    rd_n    = 1'b0;
    unique case (state)
      IDLE: if (acc) begin
        rq_n.wr   = bus.mem_req_rw[0];
        rq_n.addr = bus.mem_req_addr;
        rq_n.data = bus.mem_req_data;
        rq_n.tag  = bus.mem_req_tag;
        rd_n      = ~bus.mem_req_rw[0];
        base_n    = bus.mem_req_addr;
        btag_n    = bus.mem_req_tag;
        cnt_n     = CW'(1);
        if (bus.mem_req_rw == 2'b00)      state_n = RD_BURST;
        else if (bus.mem_req_rw == 2'b11) state_n = WR_BURST;
      end
      RD_BURST: begin
        rd_n      = 1'b1;
        rq_n.addr = base + ADDR_W'(cnt);
        rq_n.tag  = btag;
        cnt_n     = cnt + 1'b1;
        if (last) state_n = IDLE;
      end
      WR_BURST: if (acc) begin
        rq_n.wr   = 1'b1;
        rq_n.addr = base + ADDR_W'(cnt);
        rq_n.data = bus.mem_req_data;
        cnt_n     = cnt + 1'b1;
        if (last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      base     <= '0;
      btag     <= '0;
      rq       <= '0;
      rdy_en   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      base     <= base_n;
      btag     <= btag_n;
      rq       <= rq_n;
      rdy_en   <= 1'b1;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], rd_n};
    end
  end

  // SRAM port: the registered request is issued here; storage is never reset
  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] dpipe [1:RD_LAT];
  meta_t             mpipe [1:RD_LAT];
  logic              in_rng;
  logic [MEM_AW-1:0] idx;

  assign in_rng = ({1'b0, rq.addr} < (ADDR_W+1)'(DEPTH));
  assign idx    = rq.addr[MEM_AW-1:0];

  always_ff @(posedge clk) begin
    if (rq.wr && in_rng) mem[idx] <= rq.data;
    if (vld_pipe[0]) begin
      dpipe[1] <= in_rng ? mem[idx] : '0;
      mpipe[1] <= '{nack: ~in_rng, tag: rq.tag};
    end
    for (int i = 2; i <= RD_LAT; i++) begin
      dpipe[i] <= dpipe[i-1];
      mpipe[i] <= mpipe[i-1];
    end
  end

  // Data/tag hold between responses; nack only qualifies a valid beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_resp_val  <= 1'b0;
      bus.mem_resp_nack <= 1'b0;
      bus.mem_resp_data <= '0;
      bus.mem_resp_tag  <= '0;
    end else begin
      bus.mem_resp_val  <= vld_pipe[RD_LAT];
      bus.mem_resp_nack <= vld_pipe[RD_LAT] & mpipe[RD_LAT].nack;
      if (vld_pipe[RD_LAT]) begin
        bus.mem_resp_data <= dpipe[RD_LAT];
        bus.mem_resp_tag  <= mpipe[RD_LAT].tag;
      end
    end
  end
endmodule

// File: tb/tb_sram_l2_burst.sv
// Directed bench driving two instances (full depth and DEPTH=12288) with the
// same stimulus; per-instance scoreboards check data, tag, nack and arrival cycle.
module tb_sram_l2_burst;
  localparam int DW = 128;
  localparam int AW = 14;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          val;
  logic [1:0]    rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [TW-1:0] tag;

  sram_l2_burst_if #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) if0 ();
  sram_l2_burst_if #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) if1 ();

  assign if0.mem_req_val  = val;
  assign if0.mem_req_rw   = rw;
  assign if0.mem_req_addr = addr;
  assign if0.mem_req_data = data;
  assign if0.mem_req_tag  = tag;
  assign if1.mem_req_val  = val;
  assign if1.mem_req_rw   = rw;
  assign if1.mem_req_addr = addr;
  assign if1.mem_req_data = data;
  assign if1.mem_req_tag  = tag;

  sram_l2_burst #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16384), .TAG_W(TW), .BURST(4), .RD_LAT(2))
    u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  sram_l2_burst #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(12288), .TAG_W(TW), .BURST(4), .RD_LAT(2))
    u1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          n;
    int            c;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s act=%b exp=%b", nm, act, exp); end
  endtask
  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s act=%h exp=%h", nm, act, exp); end
  endtask
  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin errors++; $display("FAIL %s act=%0d exp=%0d", nm, act, exp); end
  endtask

  task automatic cmp(input string p, input exp_t e, input logic n,
                     input logic [DW-1:0] d, input logic [TW-1:0] t);
    chkd({p, "_data"}, d, e.d);
    chki({p, "_tag"}, int'(t), int'(e.t));
    chkb({p, "_nack"}, n, e.n);
    chki({p, "_cycle"}, cyc, e.c);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if0.mem_resp_val) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_unexpected_resp act=tag %0d exp=no response", if0.mem_resp_tag);
      end else begin
        e = q0.pop_front();
        cmp("u0", e, if0.mem_resp_nack, if0.mem_resp_data, if0.mem_resp_tag);
      end
    end else chkb("u0_nack_idle", if0.mem_resp_nack, 1'b0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.mem_resp_val) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_unexpected_resp act=tag %0d exp=no response", if1.mem_resp_tag);
      end else begin
        e = q1.pop_front();
        cmp("u1", e, if1.mem_resp_nack, if1.mem_resp_data, if1.mem_resp_tag);
      end
    end else chkb("u1_nack_idle", if1.mem_resp_nack, 1'b0);
  end

  // Called at a negedge; returns at the negedge after acceptance, c = cycle before the accepting edge
  task automatic beat(input logic [1:0] r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [TW-1:0] t, output int c);
    int g = 0;
    val = 1'b1; rw = r; addr = a; data = d; tag = t;
    while (!if0.mem_req_rdy && g < 16) begin @(negedge clk); g++; end
    chkb("rdy_wait", g < 16, 1'b1);
    c = cyc;
    @(negedge clk);
    val = 1'b0;
  endtask

  // Beat k of a load accepted with cycle stamp c is expected at c+4+k
  task automatic exp_ld(input int c, input int k, input logic [TW-1:0] t,
                        input logic [DW-1:0] d0, input logic n0,
                        input logic [DW-1:0] d1, input logic n1);
    exp_t e;
    e.t = t; e.c = c + 4 + k;
    e.d = d0; e.n = n0; q0.push_back(e);
    e.d = d1; e.n = n1; q1.push_back(e);
  endtask

  task automatic drain();
    int g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 40) begin @(negedge clk); g++; end
    chki("drain_pending", q0.size() + q1.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string p);
    chkb({p, "_rdy0"},  if0.mem_req_rdy, 1'b0);
    chkb({p, "_val0"},  if0.mem_resp_val, 1'b0);
    chkb({p, "_nack0"}, if0.mem_resp_nack, 1'b0);
    chkd({p, "_data0"}, if0.mem_resp_data, '0);
    chki({p, "_tag0"},  int'(if0.mem_resp_tag), 0);
    chkb({p, "_u1rdy0"},  if1.mem_req_rdy, 1'b0);
    chkb({p, "_u1val0"},  if1.mem_resp_val, 1'b0);
    chkd({p, "_u1data0"}, if1.mem_resp_data, '0);
  endtask

  function automatic logic [DW-1:0] dv(input logic [31:0] base, input int k);
    logic [31:0] w;
    w = base + 32'(k);
    return {4{w}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [DW-1:0] a5;
    logic [DW-1:0] f;
    a5 = {16{8'hA5}};
    f  = {8{16'h1234}};
    val = 1'b0; rw = 2'b00; addr = '0; data = '0; tag = '0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chkb("rdy_after_rst", if0.mem_req_rdy, 1'b1);

    // Store then load next cycle
    beat(2'b01, 14'h0010, a5, 5'd0, c);
    beat(2'b10, 14'h0010, '0, 5'd3, c);
    exp_ld(c, 0, 5'd3, a5, 1'b0, a5, 1'b0);

    // Burst store / load wrapping past the top of the address space
    beat(2'b11, 14'h3FFE, dv(32'hD000_0000, 0), 5'd0, c);
    for (int k = 1; k < 4; k++) beat(2'b10, 14'h0555, dv(32'hD000_0000, k), 5'd9, c);
    beat(2'b00, 14'h3FFE, '0, 5'd7, c);
    for (int k = 0; k < 4; k++)
      exp_ld(c, k, 5'd7, dv(32'hD000_0000, k), 1'b0,
             (k < 2) ? '0 : dv(32'hD000_0000, k), (k < 2));
    for (int k = 0; k < 3; k++) begin
      chkb("rd_burst_rdy_low", if0.mem_req_rdy, 1'b0);
      @(negedge clk);
    end
    chkb("rd_burst_rdy_back", if0.mem_req_rdy, 1'b1);

    // Burst store with 2-cycle gaps; burst beats carry rw=00 which must be ignored
    beat(2'b11, 14'h0100, dv(32'hE000_0000, 0), 5'd0, c);
    for (int k = 1; k < 4; k++) begin
      repeat (2) @(negedge clk);
      beat(2'b00, 14'h0200, dv(32'hE000_0000, k), 5'd0, c);
    end
    beat(2'b10, 14'h0103, '0, 5'd4, c);
    exp_ld(c, 0, 5'd4, dv(32'hE000_0000, 3), 1'b0, dv(32'hE000_0000, 3), 1'b0);
    beat(2'b00, 14'h0100, '0, 5'd9, c);
    for (int k = 0; k < 4; k++)
      exp_ld(c, k, 5'd9, dv(32'hE000_0000, k), 1'b0, dv(32'hE000_0000, k), 1'b0);
    drain();

    // Address 0x3000 is in range for u0, out of range for u1
    beat(2'b01, 14'h3000, f, 5'd0, c);
    beat(2'b10, 14'h3000, '0, 5'd2, c);
    exp_ld(c, 0, 5'd2, f, 1'b0, '0, 1'b1);

    // Back-to-back single loads, tags 0..7
    for (int i = 0; i < 8; i++) begin
      beat(2'b10, 14'h0100 + 14'(i % 4), '0, 5'(i), c);
      exp_ld(c, 0, 5'(i), dv(32'hE000_0000, i % 4), 1'b0, dv(32'hE000_0000, i % 4), 1'b0);
    end
    drain();
    repeat (2) @(negedge clk);
    chki("hold_tag", int'(if0.mem_resp_tag), 7);
    chkd("hold_data", if0.mem_resp_data, dv(32'hE000_0000, 3));

    // Reset pulse while a burst load is issuing its second beat
    beat(2'b00, 14'h0100, '0, 5'd5, c);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chkb("rdy_after_midrst", if0.mem_req_rdy, 1'b1);
    repeat (8) @(negedge clk);

    // Memory contents survive reset
    beat(2'b10, 14'h0010, '0, 5'd1, c);
    exp_ld(c, 0, 5'd1, a5, 1'b0, a5, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_l2_burst.md
SRAM_L2_BURST -- requirements
Module: sram_l2_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning data beat width in bits.
REQ-002 SHALL have parameter ADDR_W, default 14, meaning beat-address width in bits.
REQ-003 SHALL have parameter DEPTH, default 16384, meaning number of implemented beats; legal range 1..2^ADDR_W.
REQ-004 SHALL have parameter TAG_W, default 5, meaning request/response tag width.
REQ-005 SHALL have parameter BURST, default 4, meaning beats per burst; power of two, at least 2.
REQ-006 SHALL have parameter RD_LAT, default 2, meaning SRAM read latency in cycles; at least 1.
REQ-007 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit, meaning reset: asynchronous assert, active-low.
REQ-009 SHALL have port mem_req_val, input, 1 bit, meaning request/beat valid.
REQ-010 SHALL have port mem_req_rdy, output, 1 bit, meaning block can accept a request/beat this cycle.
REQ-011 SHALL have port mem_req_rw, input, 2 bits: 00 burst load, 10 single load, 01 single store, 11 burst store.
REQ-012 SHALL have port mem_req_addr, input, ADDR_W bits, meaning beat address.
REQ-013 SHALL have port mem_req_data, input, DATA_W bits, meaning store data.
REQ-014 SHALL have port mem_req_tag, input, TAG_W bits, meaning request tag.
REQ-015 SHALL have port mem_resp_val, output, 1 bit, meaning response beat valid.
REQ-016 SHALL have port mem_resp_nack, output, 1 bit, meaning response beat is for an out-of-range address.
REQ-017 SHALL have port mem_resp_data, output, DATA_W bits, meaning load data.
REQ-018 SHALL have port mem_resp_tag, output, TAG_W bits, meaning tag of the originating load.

Function
REQ-019 SHALL accept a request or beat only on a cycle where mem_req_val and mem_req_rdy are both 1.
REQ-020 SHALL implement FSM states IDLE, RD_BURST and WR_BURST.
REQ-021 IDLE: rdy=1; accepted rw=00 goes to RD_BURST; accepted rw=11 goes to WR_BURST; rw=10/01 stay in IDLE.
REQ-022 RD_BURST: rdy=0; one read is issued per cycle to base+1 .. base+BURST-1; after the last issue, rdy=1 and state returns to IDLE.
REQ-023 WR_BURST: rdy=1; each accepted beat writes mem_req_data to base+k, with k counting 1..BURST-1; rw, addr and tag of these beats are ignored.
REQ-024 WR_BURST: returns to IDLE on acceptance of beat BURST-1; gaps (val=0) are allowed and hold the beat count.
REQ-025 SHALL compute burst beat addresses as base+k modulo 2^ADDR_W; no alignment is required.
REQ-026 SHALL register each accepted request, then issue the SRAM access the following cycle, in strict acceptance order through one SRAM port.
REQ-027 SHALL assert mem_resp_val exactly 1+RD_LAT cycles after each read issue, with the load tag.
REQ-028 Burst load responses SHALL be BURST back-to-back beats in address order; a single load SHALL give one beat.
REQ-029 Stores SHALL produce no response.
REQ-030 A beat address >= DEPTH SHALL suppress the write; a load to such an address SHALL respond with nack=1 and data=0 at normal latency.
REQ-031 A load accepted in the cycle after a store to the same address SHALL return the new data (no read-before-write hazard).
REQ-032 mem_resp_data and mem_resp_tag SHALL hold their last values when mem_resp_val=0; mem_resp_nack SHALL be 0 whenever mem_resp_val=0.

Reset
REQ-033 While reset_n=0: rdy=0, resp_val=0, resp_nack=0, resp_data=0, resp_tag=0, state=IDLE, counters=0, pipeline valids=0.
REQ-034 SHALL assert mem_req_rdy on the first rising clk edge after reset_n deasserts.
REQ-035 Reset asserted mid-burst SHALL discard all in-flight beats and responses; SRAM contents are not cleared, and partial burst-store writes persist.

Verification
REQ-036 Single store 01, addr 0x0010, data 0xA5..A5; next cycle single load 10, tag 3 -> one resp 3 cycles after load accept: data 0xA5..A5, tag 3, nack 0.
REQ-037 Burst store 11, base 0x3FFE, beats D0..D3; then burst load 00, tag 7 -> resps D0..D3 back-to-back, addresses 3FFE,3FFF,0000,0001 (wrap), rdy low 3 cycles.
REQ-038 Burst store with val gaps of 2 cycles between beats -> all 4 beats written; state returns to IDLE only after 4th beat.
REQ-039 DEPTH=12288: load 10 to 0x3000, tag 2 -> resp nack=1, data 0; store 01 to 0x3000 -> no memory change.
REQ-040 reset_n pulsed low during RD_BURST beat 2 -> no further resp_val, all outputs 0; rdy=1 one edge after release.
REQ-041 Back-to-back single loads every cycle, tags 0..7 -> eight consecutive resps in order with matching tags.
